// File: rtl/sa_serializer.sv
// Parallel-to-serial operand stage for the serial adder: LSB-first bit pairs with
// first/last frame markers and a one-word pending buffer for bubble-free frames.
module sa_serializer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_a,
  output logic             ser_b,
  output logic             ser_valid,
  output logic             ser_first,
  output logic             ser_last,
  input  logic             ser_ready,
  output logic             busy
);

  typedef enum logic {IDLE, SHIFT} state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [WIDTH-1:0] pend_a;
  logic [WIDTH-1:0] pend_b;
  logic             pend_full;

  logic accept;
  logic xfer;
  logic last_xfer;
  logic direct;

  assign in_ready  = ~rst & ~pend_full;
  assign accept    = in_valid & in_ready;
  assign xfer      = (state == SHIFT) & ser_ready;
  assign last_xfer = xfer & (cnt == LAST_IDX);
  // A word bypasses the pending slot only when the shifter is free this edge.
  assign direct    = accept & ((state == IDLE) | (last_xfer & ~pend_full));

  assign ser_valid = (state == SHIFT);
  assign ser_a     = ser_valid & sh_a[0];
  assign ser_b     = ser_valid & sh_b[0];
  assign ser_first = ser_valid & (cnt == '0);
  assign ser_last  = ser_valid & (cnt == LAST_IDX);
  assign busy      = ser_valid | pend_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      sh_a      <= '0;
      sh_b      <= '0;
      pend_a    <= '0;
      pend_b    <= '0;
      pend_full <= 1'b0;
    end else begin
      if (state == IDLE) begin
        if (accept) begin
          sh_a  <= in_a;
          sh_b  <= in_b;
          cnt   <= '0;
          state <= SHIFT;
        end
      end else if (xfer) begin
        if (cnt == LAST_IDX) begin
          cnt <= '0;
          if (pend_full) begin
            sh_a      <= pend_a;
            sh_b      <= pend_b;
            pend_full <= 1'b0;
          end else if (accept) begin
            sh_a <= in_a;
            sh_b <= in_b;
          end else begin
            state <= IDLE;
          end
        end else begin
          sh_a <= sh_a >> 1;
          sh_b <= sh_b >> 1;
          cnt  <= cnt + 1'b1;
        end
      end

      // accept implies pend_full was low, so this never fights the drain above.
      if (accept && !direct) begin
        pend_a    <= in_a;
        pend_b    <= in_b;
        pend_full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sa_serializer.sv
// Scoreboard bench for sa_serializer: the driver queues expected bit pairs per
// accepted word, a negedge monitor pops and compares on every bit transfer.
module tb_sa_serializer;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [WIDTH-1:0] in_a = '0;
  logic [WIDTH-1:0] in_b = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             ser_a, ser_b, ser_valid, ser_first, ser_last;
  logic             ser_ready = 1'b1;
  logic             busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int vcount = 0;
  int run = 0;
  int max_run = 0;
  logic [3:0] exp_q[$];

  sa_serializer #(.WIDTH(WIDTH), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .in_a(in_a), .in_b(in_b), .in_valid(in_valid),
    .in_ready(in_ready), .ser_a(ser_a), .ser_b(ser_b), .ser_valid(ser_valid),
    .ser_first(ser_first), .ser_last(ser_last), .ser_ready(ser_ready), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  // Offer one word, wait for the accept edge, then queue its expected bits.
  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      output int acc_cyc, output int waits);
    logic took;
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    took = 1'b0;
    waits = 0;
    for (int n = 0; n < 100 && !took; n++) begin
      took = in_ready;
      if (!took) waits++;
      @(posedge clk);
      #1;
    end
    acc_cyc = cyc;
    in_valid = 1'b0;
    if (!took) begin
      chk("accept_timeout", 0, 1);
    end else begin
      for (int i = 0; i < WIDTH; i++)
        exp_q.push_back({a[i], b[i], (i == 0), (i == WIDTH - 1)});
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (busy) chk({name, "_idle_timeout"}, 1, 0);
  endtask

  // Monitor: one line per transferred bit pair.
  initial begin
    logic [3:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (ser_valid) begin
          vcount++;
          run++;
          if (run > max_run) max_run = run;
        end else begin
          run = 0;
        end
        if (ser_valid && ser_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_bit", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("bit{a,b,first,last}", int'({ser_a, ser_b, ser_first, ser_last}), int'(e));
          end
        end
      end
    end
  end

  initial begin
    int acc0, acc1, acc2, w0, w1, w2, v0;

    // Reset
    repeat (2) begin
      @(negedge clk);
      chk("rst_ser_valid", int'(ser_valid), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_in_ready", int'(in_ready), 0);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    #1 chk("post_rst_in_ready", int'(in_ready), 1);

    // Single word
    send(4'd1, 4'd2, acc0, w0);
    wait_idle("single");
    @(negedge clk);
    chk("single_ser_valid_after", int'(ser_valid), 0);
    chk("single_queue_drained", exp_q.size(), 0);

    // Back-to-back, in_valid held across words
    @(posedge clk);
    #1 max_run = 0;
    send(4'd3, 4'd2, acc0, w0);
    send(4'd0, 4'd1, acc1, w1);
    chk("b2b_pending_in_ready", int'(in_ready), 0);
    chk("b2b_pending_busy", int'(busy), 1);
    send(4'd0, 4'd0, acc2, w2);
    chk("b2b_third_waited", int'(w2 > 0), 1);
    wait_idle("b2b");
    chk("b2b_contiguous_valid", max_run, 12);

    // Stall at bit index 2
    @(posedge clk);
    #1 v0 = vcount;
    send(4'd5, 4'd10, acc0, w0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    ser_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_hold_ab", int'({ser_valid, ser_a, ser_b}), 3'b110);
    end
    @(posedge clk);
    #1 ser_ready = 1'b1;
    wait_idle("stall");
    @(negedge clk);
    chk("stall_valid_cycles", vcount - v0, 7);

    // Reset mid-frame with a pending word
    @(posedge clk);
    #1;
    send(4'd15, 4'd0, acc0, w0);
    send(4'd0, 4'd15, acc1, w1);
    rst = 1'b1;
    #1;
    chk("midrst_ser_valid", int'(ser_valid), 0);
    chk("midrst_busy", int'(busy), 0);
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    v0 = vcount;
    repeat (6) @(posedge clk);
    #1 chk("midrst_no_pending_emerges", vcount - v0, 0);
    send(4'd1, 4'd0, acc0, w0);
    @(negedge clk);
    chk("midrst_restart_first_a", int'({ser_first, ser_a}), 2'b11);
    wait_idle("midrst");

    // End of frame with pending full while a=6 is offered
    @(posedge clk);
    #1;
    send(4'd9, 4'd3, acc0, w0);
    send(4'd2, 4'd4, acc1, w1);
    send(4'd6, 4'd1, acc2, w2);
    chk("eof_offer_accept_delay", acc2 - acc0, 5);
    wait_idle("eof");
    @(negedge clk);
    chk("final_queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
